// File: rtl/lfsr_gen.sv
// lfsr_gen: parameterised Fibonacci/Galois LFSR with seed load, step count, wrap and lock-up recovery pulses.
module lfsr_gen #(
  parameter int              WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
  parameter bit              GALOIS     = 1'b0,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic             q,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             zero_fix
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be 2..32");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_gen: TAPS MSB must be set");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: RESET_SEED must be nonzero");
  end
  logic [WIDTH-1:0] state_q, state_d, ref_q, ref_d, count_q, count_d, step;
  logic             wrap_q, wrap_d, zfix_q, zfix_d, fb, msb, hit, zero;
  always_comb begin
    fb      = ^(state_q & TAPS);
    msb     = state_q[WIDTH-1];
    step    = GALOIS ? ({state_q[WIDTH-2:0], msb} ^ ({TAPS[WIDTH-2:0], 1'b0} & {WIDTH{msb}}))
                     : {state_q[WIDTH-2:0], fb};
    zero    = (state_q == '0);
    hit     = (step == ref_q);
    state_d = load ? seed : !en ? state_q : zero ? ONE : step;
    ref_d   = load ? seed : (en && zero) ? ONE : ref_q;
    // the all-zero state is the only lock-up; leaving it restarts the reference at 1
    count_d = (load || (en && (zero || hit))) ? '0 : en ? count_q + ONE : count_q;
    wrap_d  = !load && en && !zero && hit;
    zfix_d  = !load && en && zero;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_SEED;
      ref_q   <= RESET_SEED;
      count_q <= '0;
      wrap_q  <= 1'b0;
      zfix_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      zfix_q  <= zfix_d;
    end
  end
  assign q        = GALOIS ? msb : fb;
  assign out      = state_q;
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign zero_fix = zfix_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: checks Fibonacci, Galois and 8-bit LFSR instances against a bench model every cycle.
module tb_lfsr_gen;
  logic clk, rst, load, en;
  logic [3:0] seed;
  logic q0, q1, q2, w0, w1, w2, z0, z1, z2;
  logic [3:0] o0, o1, c0, c1;
  logic [7:0] o2, c2;
  int n_cmp = 0, n_bad = 0, p2 = 0, wraps2 = 0;
  typedef struct { logic [31:0] st, rf, cnt; bit wr, zf; } mdl_t;
  mdl_t m0, m1, m2;
  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  lfsr_gen dut0 (.clk(clk), .rst(rst), .load(load), .seed(seed), .en(en),
                 .q(q0), .out(o0), .count(c0), .wrap(w0), .zero_fix(z0));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(1'b1)) dut1 (.clk(clk), .rst(rst), .load(load),
                 .seed(seed), .en(en), .q(q1), .out(o1), .count(c1), .wrap(w1), .zero_fix(z1));
  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8)) dut2 (.clk(clk), .rst(rst), .load(1'b0), .seed(8'h00),
                 .en(1'b1), .q(q2), .out(o2), .count(c2), .wrap(w2), .zero_fix(z2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_step(logic [31:0] s, int w, logic [31:0] taps, bit gal);
    logic [31:0] mask = (32'd1 << w) - 1;
    if (!gal) return ((s << 1) | 32'(^(s & taps))) & mask;
    return ((s << 1) & mask) ^ (s[w-1] ? (((taps << 1) | 1) & mask) : 32'd0);
  endfunction

  function automatic bit m_q(logic [31:0] s, int w, logic [31:0] taps, bit gal);
    return gal ? s[w-1] : ^(s & taps);
  endfunction

  function automatic mdl_t m_next(mdl_t m, bit ld, logic [31:0] sd, bit e, int w, logic [31:0] taps, bit gal);
    mdl_t n = m;
    n.wr = 0;
    n.zf = 0;
    if (ld) begin
      n.st = sd; n.rf = sd; n.cnt = 0;
    end else if (e && m.st == 0) begin
      n.st = 1; n.rf = 1; n.cnt = 0; n.zf = 1;
    end else if (e) begin
      n.st = m_step(m.st, w, taps, gal);
      n.wr = (n.st == m.rf);
      n.cnt = n.wr ? 0 : m.cnt + 1;
    end
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_one(string t, mdl_t m, int w, logic [31:0] taps, bit gal,
                         logic [31:0] o, logic [31:0] c, bit qq, bit wr, bit zf);
    chk({t, "_out"}, o, m.st);
    chk({t, "_count"}, c, m.cnt);
    chk({t, "_q"}, 32'(qq), 32'(m_q(m.st, w, taps, gal)));
    chk({t, "_wrap"}, 32'(wr), 32'(m.wr));
    chk({t, "_zero_fix"}, 32'(zf), 32'(m.zf));
  endtask

  task automatic rst_models();
    m0 = '{st: 1, rf: 1, cnt: 0, wr: 0, zf: 0};
    m1 = m0;
    m2 = m0;
    p2 = 0;
  endtask

  task automatic cmp_all();
    cmp_one("d0", m0, 4, 32'hC, 0, 32'(o0), 32'(c0), q0, w0, z0);
    cmp_one("d1", m1, 4, 32'hC, 1, 32'(o1), 32'(c1), q1, w1, z1);
    cmp_one("d2", m2, 8, 32'hB8, 0, 32'(o2), 32'(c2), q2, w2, z2);
    if (w2) begin
      chk("d2_period", p2, 255);
      p2 = 0;
      wraps2++;
    end
  endtask

  task automatic upd();
    if (!rst) rst_models();
    else begin
      m0 = m_next(m0, load, 32'(seed), en, 4, 32'hC, 0);
      m1 = m_next(m1, load, 32'(seed), en, 4, 32'hC, 1);
      m2 = m_next(m2, 0, 0, 1, 8, 32'hB8, 0);
      p2++;
    end
  endtask

  task automatic tick(bit ld, logic [3:0] sd, bit e);
    load = ld; seed = sd; en = e;
    @(posedge clk);
    upd();
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    load = 0; seed = 0; en = 0;
    rst = 1'b0;
    rst_models();
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("rst_out", 32'(o0), 1);
    rst = 1'b1;
    // 15-step default sequence pinned by literal table
    for (int i = 1; i <= 15; i++) begin
      tick(0, 0, 1);
      chk("seq_out", 32'(o0), 32'(seq[i]));
      chk("seq_wrap", 32'(w0), (i == 15) ? 1 : 0);
    end
    chk("seq_count_back", 32'(c0), 0);
    tick(0, 0, 0);
    chk("hold_wrap_drop", 32'(w0), 0);
    // zero seed then lock-up recovery
    tick(1, 4'h0, 0);
    chk("zload_out", 32'(o0), 0);
    chk("zload_zf", 32'(z0), 0);
    tick(0, 0, 1);
    chk("zfix_out", 32'(o0), 1);
    chk("zfix_pulse", 32'(z0), 1);
    chk("zfix_nowrap", 32'(w0), 0);
    for (int i = 1; i <= 15; i++) begin
      tick(0, 0, 1);
      chk("zfix_wrap", 32'(w0), (i == 15) ? 1 : 0);
    end
    // Galois single step from 1000
    tick(1, 4'h8, 0);
    chk("gal_q_before", 32'(q1), 1);
    tick(0, 0, 1);
    chk("gal_out", 32'(o1), 32'h9);
    chk("gal_count", 32'(c1), 1);
    // load overrides en mid-sequence
    repeat (3) tick(0, 0, 1);
    tick(1, 4'h6, 1);
    chk("ld_en_out", 32'(o0), 32'h6);
    chk("ld_en_count", 32'(c0), 0);
    chk("ld_en_wrap", 32'(w0), 0);
    for (int i = 1; i <= 15; i++) begin
      tick(0, 0, 1);
      chk("ld_wrap", 32'(w0), (i == 15) ? 1 : 0);
    end
    // asynchronous reset between edges
    repeat (4) tick(0, 0, 1);
    load = 0; en = 1;
    @(posedge clk);
    upd();
    #2 rst = 1'b0;
    rst_models();
    #1;
    chk("arst_out", 32'(o0), 1);
    chk("arst_count", 32'(c0), 0);
    @(negedge clk);
    cmp_all();
    tick(1, 4'h5, 1);
    tick(0, 0, 1);
    chk("arst_hold", 32'(o0), 1);
    rst = 1'b1;
    tick(0, 0, 1);
    chk("arst_first_step", 32'(o0), 32'h2);
    // long free run for the 8-bit period
    repeat (600) tick(0, 0, 1);
    chk("d2_wraps_seen", 32'(wraps2 >= 2), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
